// File: rtl/benes_cfg_sequencer.sv
// Config sequencer for a 5-stage 8x8 Benes network: loads each stage's switch controls
// in lock-step with the data wavefront so every vector sees a single, consistent config.
module benes_cfg_sequencer #(
  parameter int unsigned STAGE_GAP = 2,
  parameter int unsigned PIPE_LAT  = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  input  logic [19:0] cfg_data,
  output logic        cfg_ready,
  output logic [3:0]  switch_set [0:4],
  output logic        cfg_applied,
  input  logic        in_valid,
  output logic        out_valid,
  output logic        out_epoch,
  output logic        cur_epoch
);

  localparam int unsigned NumStages = 5;
  localparam int unsigned SkewLen   = 4 * STAGE_GAP;
  localparam int unsigned CntW      = $clog2(SkewLen + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SkewLen - 1);

  typedef enum logic [0:0] {StIdle, StSkew} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [19:0]       shadow_q;
  logic [3:0]        sw_q [NumStages];
  logic              epoch_q;
  logic              applied_q;
  logic              accept;
  logic              last_load;
  logic [NumStages-1:0] stage_load;
  logic [PIPE_LAT-1:0]  vld_q;
  logic [PIPE_LAT-1:0]  ep_q;

  // Next-state and handshake decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    last_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          accept  = 1'b1;
          state_d = StSkew;
          cnt_d   = '0;
        end
      end
      StSkew: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          last_load = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage k loads STAGE_GAP*k edges after accept; stage 0 loads at accept itself.
  always_comb begin
    stage_load    = '0;
    stage_load[0] = accept;
    for (int k = 1; k < NumStages; k++) begin
      stage_load[k] = (state_q == StSkew) && (cnt_q == CntW'(STAGE_GAP * k - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shadow_q  <= '0;
      epoch_q   <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      applied_q <= last_load;
      if (accept) begin
        shadow_q <= cfg_data;
        epoch_q  <= ~epoch_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NumStages; k++) begin
        sw_q[k] <= 4'h0;
      end
    end else begin
      if (stage_load[0]) begin
        sw_q[0] <= cfg_data[3:0];
      end
      for (int k = 1; k < NumStages; k++) begin
        if (stage_load[k]) begin
          sw_q[k] <= shadow_q[4*k +: 4];
        end
      end
    end
  end

  // Epoch is sampled before the accept edge toggles it, so a vector entering on the
  // accept edge is tagged (and routed) with the old config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ep_q  <= '0;
    end else begin
      vld_q[0] <= in_valid;
      ep_q[0]  <= in_valid & epoch_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        ep_q[i]  <= ep_q[i-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NumStages; k++) begin
      switch_set[k] = sw_q[k];
    end
  end

  assign cfg_ready   = rst_n & (state_q == StIdle);
  assign cfg_applied = applied_q;
  assign cur_epoch   = epoch_q;
  assign out_valid   = vld_q[PIPE_LAT-1];
  assign out_epoch   = vld_q[PIPE_LAT-1] & ep_q[PIPE_LAT-1];

endmodule

// File: doc/benes_cfg_sequencer.md
BENES_CFG_SEQUENCER -- requirements
Module: benes_cfg_sequencer

Interface
REQ-001 Parameter STAGE_GAP, default 2, SHALL set the clock edges between consecutive network stages capturing the same vector.
REQ-002 Parameter PIPE_LAT, default 9, SHALL set the cycles from in_valid to out_valid; it SHALL equal 4*STAGE_GAP+1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_valid  input  1  software config word valid.
REQ-006 cfg_data  input  20  config word; bits [4k+3:4k] are the 4 switch controls for stage k, k=0..4.
REQ-007 cfg_ready  output  1  sequencer can accept a config word.
REQ-008 switch_set  output  5x4 ([3:0] switch_set[0:4])  per-stage switch controls driving the 8x8 network.
REQ-009 cfg_applied  output  1  one-cycle pulse when all 5 stages hold the new config.
REQ-010 in_valid  input  1  a vector is on the network input this cycle.
REQ-011 out_valid  output  1  the network output carries a valid vector this cycle.
REQ-012 out_epoch  output  1  config epoch the output vector was routed with.
REQ-013 cur_epoch  output  1  epoch of the config most recently accepted.

Function
REQ-014 States SHALL be IDLE and SKEW; cfg_ready SHALL be 1 exactly in IDLE.
REQ-015 Accept SHALL occur at edge E where cfg_valid=1 and cfg_ready=1; cfg_data SHALL be captured into a shadow register at E.
REQ-016 At E: FSM -> SKEW, skew counter cleared to 0, cur_epoch toggles, switch_set[0] loads shadow bits [3:0].
REQ-017 switch_set[k] SHALL load shadow bits [4k+3:4k] at edge E+STAGE_GAP*k (default E+2k) and hold otherwise.
REQ-018 Skew counter SHALL increment each edge in SKEW; at edge E+4*STAGE_GAP (default E+8) FSM SHALL return to IDLE.
REQ-019 cfg_ready SHALL be 0 for cycles E..E+7 and 1 from cycle E+8; earliest next accept at edge E+9.
REQ-020 cfg_applied SHALL be 1 only in cycle E+8 (following the last stage load).
REQ-021 cfg_valid while cfg_ready=0 SHALL be ignored; source holds cfg_data until accepted.
REQ-022 in_valid SHALL be tracked by a PIPE_LAT-deep shift register; out_valid SHALL equal in_valid delayed PIPE_LAT cycles, independent of FSM state.
REQ-023 Each in_valid SHALL sample cur_epoch in the same cycle; out_epoch SHALL be that sample delayed with out_valid; out_epoch SHALL be 0 when out_valid=0.
REQ-024 Consistency: vector with in_valid sampled at edge c SHALL be routed entirely by old config if c<=E, entirely by new config if c>E; no mixed routing for any c.
REQ-025 in_valid during SKEW SHALL be legal and not stall; back-to-back in_valid every cycle SHALL yield back-to-back out_valid.
REQ-026 Simultaneous accept and in_valid at edge E: that vector SHALL carry the old epoch and old routing.

Reset
REQ-027 rst_n=0 SHALL immediately force: FSM IDLE, counter 0, shadow 0, all switch_set[k]=4'h0, cur_epoch=0, cfg_applied=0, out_valid=0, out_epoch=0, in_valid shift register cleared.
REQ-028 cfg_ready SHALL be 0 while rst_n=0 and 1 in first cycle after deassertion.
REQ-029 Reset during SKEW SHALL discard the partial config; no cfg_applied pulse SHALL follow.

Verification
REQ-030 Reset release, cfg_data=20'hABCDE accepted at edge E -> switch_set[0]=E at E, [1]=D at E+2, [2]=C at E+4, [3]=B at E+6, [4]=A at E+8; cfg_applied only in cycle E+8; cur_epoch=1.
REQ-031 cfg_valid held high continuously with two words -> second accept at edge E+9, cfg_ready low exactly 8 cycles per word.
REQ-032 in_valid every cycle from E-3 to E+3 across accept at E -> out_valid continuous 9 cycles later; out_epoch=0 for vectors sampled at edges <=E, 1 for >E.
REQ-033 rst_n pulsed low at edge E+5 mid-SKEW -> all switch_set read 0 asynchronously, no cfg_applied, cfg_ready=1 after release, out_valid 0 for all prior vectors.
REQ-034 Single in_valid pulse with no config activity -> single out_valid pulse exactly 9 cycles later, out_epoch=cur_epoch at injection.
